pc_sequencer: RTL and testbench

- Owns the program counter and the next-PC decision for the single-cycle/multi-cycle datapath.
- Consumes the branch-taken decision (validJump) produced by the branch-condition logic.
- Computes the next PC as sequential, relative, absolute or register target.
- Produces the link address for branch-and-link, and halts or faults on illegal targets.

---
 rtl/pc_sequencer.sv | 166 ++++++++++++++++
 tb/tb_pc_sequencer.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// Program counter owner: picks the next PC (sequential, relative, absolute or
// register target), emits the branch-and-link write and traps illegal targets.
module pc_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h00000000,
    parameter int unsigned PC_STEP  = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        advance,
    input  logic        is_branch,
    input  logic        validJump,
    input  logic [1:0]  target_sel,
    input  logic [25:0] imm,
    input  logic [31:0] reg_target,
    input  logic        is_link,
    input  logic        halt_req,
    output logic [31:0] pc,
    output logic        pc_valid,
    output logic [31:0] link_addr,
    output logic        link_we,
    output logic        fault,
    output logic [1:0]  state
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_HALT  = 2'b10,
        ST_FAULT = 2'b11
    } state_t;

    localparam logic [31:0] STEP_C = PC_STEP[31:0];

    state_t      state_r;
    state_t      next_state_s;
    logic [31:0] seq_pc_s;
    logic [31:0] target_s;
    logic        taken_s;
    logic        bad_target_s;
    logic [31:0] pc_next_s;
    logic        pc_valid_next_s;
    logic [31:0] link_addr_next_s;
    logic        link_we_next_s;
    logic        fault_next_s;

    assign seq_pc_s = pc + STEP_C;
    assign taken_s  = is_branch & validJump;

    // Target address mux and legality check for the taken-branch path
    always_comb begin
        target_s     = seq_pc_s;
        bad_target_s = 1'b0;
        case (target_sel)
            2'b00: target_s = pc + {{4{imm[25]}}, imm, 2'b00};
            2'b01: target_s = {pc[31:28], imm, 2'b00};
            2'b10: begin
                target_s     = reg_target;
                bad_target_s = (reg_target[1:0] != 2'b00);
            end
            2'b11: bad_target_s = 1'b1;
            default: bad_target_s = 1'b1;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // FSM next-state decision; halt outranks any branch fault
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) next_state_s = ST_RUN;
                else       next_state_s = ST_IDLE;
            end
            ST_RUN: begin
                if (advance) begin
                    if (halt_req)                     next_state_s = ST_HALT;
                    else if (taken_s && bad_target_s) next_state_s = ST_FAULT;
                    else                              next_state_s = ST_RUN;
                end else begin
                    next_state_s = ST_RUN;
                end
            end
            ST_HALT: begin
                if (start) next_state_s = ST_RUN;
                else       next_state_s = ST_HALT;
            end
            ST_FAULT: next_state_s = ST_FAULT;
            default:  next_state_s = ST_FAULT;
        endcase
    end

    // FSM output decision: next values of pc, valid, link and fault registers
    always_comb begin
        pc_next_s        = pc;
        pc_valid_next_s  = pc_valid;
        link_addr_next_s = link_addr;
        link_we_next_s   = 1'b0;
        fault_next_s     = fault;
        case (state_r)
            ST_IDLE, ST_HALT: begin
                if (start) pc_valid_next_s = 1'b1;
                else       pc_valid_next_s = 1'b0;
            end
            ST_RUN: begin
                if (advance) begin
                    if (halt_req) begin
                        pc_next_s       = seq_pc_s;
                        pc_valid_next_s = 1'b0;
                    end else if (taken_s && bad_target_s) begin
                        fault_next_s    = 1'b1;
                        pc_valid_next_s = 1'b0;
                    end else if (taken_s) begin
                        pc_next_s = target_s;
                        if (is_link) begin
                            link_addr_next_s = seq_pc_s;
                            link_we_next_s   = 1'b1;
                        end else begin
                            link_we_next_s   = 1'b0;
                        end
                    end else begin
                        pc_next_s = seq_pc_s;
                    end
                end else begin
                    pc_next_s = pc;
                end
            end
            ST_FAULT: begin
                fault_next_s    = 1'b1;
                pc_valid_next_s = 1'b0;
            end
            default: begin
                fault_next_s    = 1'b1;
                pc_valid_next_s = 1'b0;
            end
        endcase
    end

    // Registered datapath outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc        <= RESET_PC;
            pc_valid  <= 1'b0;
            link_addr <= 32'h00000000;
            link_we   <= 1'b0;
            fault     <= 1'b0;
        end else begin
            pc        <= pc_next_s;
            pc_valid  <= pc_valid_next_s;
            link_addr <= link_addr_next_s;
            link_we   <= link_we_next_s;
            fault     <= fault_next_s;
        end
    end

    assign state = state_r;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed self-checking bench for pc_sequencer with hand-computed expectations.
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        advance;
    logic        is_branch;
    logic        validJump;
    logic [1:0]  target_sel;
    logic [25:0] imm;
    logic [31:0] reg_target;
    logic        is_link;
    logic        halt_req;
    logic [31:0] pc;
    logic        pc_valid;
    logic [31:0] link_addr;
    logic        link_we;
    logic        fault;
    logic [1:0]  state;

    int total = 0;
    int bad   = 0;

    pc_sequencer dut (
        .clk(clk), .rst(rst), .start(start), .advance(advance),
        .is_branch(is_branch), .validJump(validJump), .target_sel(target_sel),
        .imm(imm), .reg_target(reg_target), .is_link(is_link), .halt_req(halt_req),
        .pc(pc), .pc_valid(pc_valid), .link_addr(link_addr), .link_we(link_we),
        .fault(fault), .state(state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        start = 1'b0; advance = 1'b0; is_branch = 1'b0; validJump = 1'b0;
        target_sel = 2'b00; imm = 26'h0; reg_target = 32'h0; is_link = 1'b0;
        halt_req = 1'b0;
    endtask

    task automatic branch(input logic vj, input logic [1:0] sel, input logic [25:0] im,
                          input logic [31:0] rt, input logic lk);
        advance = 1'b1; is_branch = 1'b1; validJump = vj; target_sel = sel;
        imm = im; reg_target = rt; is_link = lk; halt_req = 1'b0;
    endtask

    initial begin
        idle_inputs();
        rst = 1'b1;
        #12;
        check("rst_pc", pc, 32'h0);
        check("rst_valid", {31'b0, pc_valid}, 32'h0);
        check("rst_state", {30'b0, state}, 32'h0);
        check("rst_fault", {31'b0, fault}, 32'h0);
        check("rst_link", link_addr, 32'h0);
        rst = 1'b0;
        step();
        advance = 1'b1;
        step();
        check("idle_adv_ignored", pc, 32'h0);
        check("idle_stays", {30'b0, state}, 32'h0);
        advance = 1'b0; start = 1'b1;
        step();
        start = 1'b0;
        check("start_state", {30'b0, state}, 32'h1);
        check("start_valid", {31'b0, pc_valid}, 32'h1);
        check("start_pc", pc, 32'h0);

        advance = 1'b1;
        step(); check("seq1", pc, 32'h4);
        step(); check("seq2", pc, 32'h8);
        step(); check("seq3", pc, 32'hC);
        advance = 1'b0;
        step(); check("hold", pc, 32'hC);

        branch(1'b1, 2'b01, 26'h40, 32'h0, 1'b0);
        step(); check("abs_0x100", pc, 32'h100);
        branch(1'b1, 2'b00, 26'h3FFFFFE, 32'h0, 1'b0);
        step(); check("rel_neg2", pc, 32'hF8);
        branch(1'b1, 2'b01, 26'h40, 32'h0, 1'b0);
        step();
        branch(1'b0, 2'b00, 26'h3FFFFFE, 32'h0, 1'b0);
        step(); check("rel_not_taken", pc, 32'h104);
        branch(1'b0, 2'b11, 26'h0, 32'h0, 1'b0);
        step(); check("nt_illegal_pc", pc, 32'h108);
        check("nt_illegal_fault", {31'b0, fault}, 32'h0);
        is_branch = 1'b0; validJump = 1'b1;
        step(); check("nonbranch_vj_pc", pc, 32'h10C);
        check("nonbranch_vj_state", {30'b0, state}, 32'h1);

        branch(1'b1, 2'b01, 26'h80, 32'h0, 1'b0);
        step(); check("abs_0x200", pc, 32'h200);
        branch(1'b1, 2'b10, 26'h0, 32'h1000, 1'b1);
        step(); check("reg_jal_pc", pc, 32'h1000);
        check("reg_jal_link", link_addr, 32'h204);
        check("reg_jal_we", {31'b0, link_we}, 32'h1);
        idle_inputs();
        step(); check("link_we_drop", {31'b0, link_we}, 32'h0);
        check("link_hold", link_addr, 32'h204);
        branch(1'b0, 2'b10, 26'h0, 32'h2000, 1'b1);
        step(); check("nt_link_pc", pc, 32'h1004);
        check("nt_link_we", {31'b0, link_we}, 32'h0);

        branch(1'b1, 2'b01, 26'h80, 32'h0, 1'b0);
        step();
        branch(1'b1, 2'b10, 26'h0, 32'h1002, 1'b1);
        step(); check("fault_state", {30'b0, state}, 32'h3);
        check("fault_flag", {31'b0, fault}, 32'h1);
        check("fault_pc", pc, 32'h200);
        check("fault_valid", {31'b0, pc_valid}, 32'h0);
        check("fault_no_link", {31'b0, link_we}, 32'h0);
        idle_inputs(); start = 1'b1; advance = 1'b1;
        step(); check("fault_absorb", {30'b0, state}, 32'h3);
        check("fault_absorb_pc", pc, 32'h200);
        idle_inputs();
        #2; rst = 1'b1; #1;
        check("fault_rst_state", {30'b0, state}, 32'h0);
        check("fault_rst_pc", pc, 32'h0);
        check("fault_rst_flag", {31'b0, fault}, 32'h0);
        step(); rst = 1'b0;

        start = 1'b1; advance = 1'b1;
        step(); check("start_adv_state", {30'b0, state}, 32'h1);
        check("start_adv_pc", pc, 32'h0);
        start = 1'b0;
        branch(1'b1, 2'b10, 26'h0, 32'hFFFFFFFC, 1'b0);
        step(); check("reg_top", pc, 32'hFFFFFFFC);
        idle_inputs(); advance = 1'b1;
        step(); check("wrap", pc, 32'h0);
        branch(1'b1, 2'b11, 26'h0, 32'h0, 1'b1);
        halt_req = 1'b1;
        step(); check("halt_state", {30'b0, state}, 32'h2);
        check("halt_pc", pc, 32'h4);
        check("halt_valid", {31'b0, pc_valid}, 32'h0);
        check("halt_no_fault", {31'b0, fault}, 32'h0);
        idle_inputs(); advance = 1'b1;
        step(); check("halt_adv_ignored", pc, 32'h4);
        advance = 1'b0; start = 1'b1;
        step(); start = 1'b0;
        check("resume_state", {30'b0, state}, 32'h1);
        check("resume_pc", pc, 32'h4);
        check("resume_valid", {31'b0, pc_valid}, 32'h1);

        branch(1'b1, 2'b10, 26'h0, 32'h3000, 1'b1);
        #3; rst = 1'b1; #1;
        check("async_pc", pc, 32'h0);
        check("async_state", {30'b0, state}, 32'h0);
        check("async_valid", {31'b0, pc_valid}, 32'h0);
        step();
        check("async_held_pc", pc, 32'h0);
        check("async_no_link", {31'b0, link_we}, 32'h0);
        idle_inputs(); rst = 1'b0;
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
